// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequential restoring divider controller.
// One (N+1)-bit trial subtractor is reused over N iterations. This module holds the
// partial remainder (R), quotient shift register (Q), divisor (D), iteration counter
// and FSM, and talks to the requester with a start/done handshake.
// Optional feature: define DIV_ZERO_FLAG_EN to add the dz port. A zero divisor then
// bypasses the iterations, and the result is ready one cycle after the start.
module div_seq_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic         dz
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    r_q, r_d;
  logic [N-1:0]    d_q, d_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef DIV_ZERO_FLAG_EN
  logic            dz_q, dz_d;
`endif

  logic [N:0]      sub_a;
  logic [N+1:0]    sub_diff;
  logic            sub_co;

  // Shared trial subtractor: A = {R, Q msb}, B = D, CO = 1 means no borrow.
  always_comb begin
    sub_a    = {r_q, q_q[N-1]};
    sub_diff = {1'b0, sub_a} - {2'b00, d_q};
    // R < D (or D == 0 with R < 2^(N-1)) keeps a non-borrowing difference below 2^N,
    // so bit N is zero whenever bit N+1 is; folding it in keeps every bit observed.
    sub_co   = ~(sub_diff[N+1] | sub_diff[N]);
  end

  // Next-state, datapath and output-register inputs.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          q_d     = dividend;
          r_d     = {N{1'b0}};
          d_d     = divisor;
          cnt_d   = {CW{1'b0}};
          state_d = ST_RUN;
`ifdef DIV_ZERO_FLAG_EN
          dz_d    = 1'b0;
          if (divisor == {N{1'b0}}) begin
            q_d     = {N{1'b1}};
            r_d     = dividend;
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            dz_d    = 1'b0;
          end
`endif
        end else if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (sub_co) begin
          r_d = sub_diff[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = sub_a[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        // The counter stops at its last value rather than wrapping.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      q_q     <= {N{1'b0}};
      r_q     <= {N{1'b0}};
      d_q     <= {N{1'b0}};
      cnt_q   <= {CW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = q_q;
  assign remainder = r_q;
`ifdef DIV_ZERO_FLAG_EN
  assign dz        = dz_q;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed bench for div_seq_ctrl (N = 8).
// Honours DIV_ZERO_FLAG_EN in the same way as the design.
module tb_div_seq_ctrl;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic         dz;
`endif

  int n_vec = 0;
  int n_err = 0;

  div_seq_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .dz        (dz)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Checks busy/done for cycles 1..8 of an operation whose start was accepted at edge 0.
  task automatic check_run(input string tag);
    for (int c = 1; c <= N; c++) begin
      check($sformatf("%s busy c%0d", tag, c), {31'd0, busy}, 32'd1);
      check($sformatf("%s done c%0d", tag, c), {31'd0, done}, 32'd0);
      tick();
    end
  endtask

  // Checks the done cycle (cycle 9) results.
  task automatic check_done(input string tag, input logic [7:0] eq, input logic [7:0] er);
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy@done"}, {31'd0, busy}, 32'd0);
    check({tag, " quot"}, {24'd0, quotient}, {24'd0, eq});
    check({tag, " rem"}, {24'd0, remainder}, {24'd0, er});
`ifdef DIV_ZERO_FLAG_EN
    check({tag, " dz"}, {31'd0, dz}, 32'd0);
`endif
  endtask

  // Full operation: accept, N run cycles, done pulse, then results held in IDLE.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    check_run(tag);
    check_done(tag, eq, er);
    tick();
    check({tag, " done drop"}, {31'd0, done}, 32'd0);
    check({tag, " quot hold"}, {24'd0, quotient}, {24'd0, eq});
    check({tag, " rem hold"}, {24'd0, remainder}, {24'd0, er});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    tick();
    tick();
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst quot", {24'd0, quotient}, 32'd0);
    check("rst rem", {24'd0, remainder}, 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("rst dz", {31'd0, dz}, 32'd0);
`endif
    rst = 1'b1;
    tick();

    // Basic operations.
    run_op("100/7", 8'd100, 8'd7, 8'd14, 8'd2);
    run_op("255/1", 8'd255, 8'd1, 8'd255, 8'd0);
    run_op("5/9", 8'd5, 8'd9, 8'd0, 8'd5);
    run_op("200/200", 8'd200, 8'd200, 8'd1, 8'd0);
    run_op("255/16", 8'd255, 8'd16, 8'd15, 8'd15);

    // Divide by zero.
`ifdef DIV_ZERO_FLAG_EN
    start = 1'b1; dividend = 8'd77; divisor = 8'd0;
    tick();
    start = 1'b0; dividend = 8'd0;
    check("77/0 done c1", {31'd0, done}, 32'd1);
    check("77/0 busy c1", {31'd0, busy}, 32'd0);
    check("77/0 quot", {24'd0, quotient}, 32'd255);
    check("77/0 rem", {24'd0, remainder}, 32'd77);
    check("77/0 dz", {31'd0, dz}, 32'd1);
    tick();
    check("77/0 done drop", {31'd0, done}, 32'd0);
    check("77/0 dz hold", {31'd0, dz}, 32'd1);
    run_op("dz clear 9/2", 8'd9, 8'd2, 8'd4, 8'd1);
`else
    run_op("77/0", 8'd77, 8'd0, 8'd255, 8'd77);
`endif

    // Reset during RUN abandons the operation.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst busy", {31'd0, busy}, 32'd0);
    check("midrst done", {31'd0, done}, 32'd0);
    check("midrst quot", {24'd0, quotient}, 32'd0);
    check("midrst rem", {24'd0, remainder}, 32'd0);
    for (int c = 0; c < 8; c++) begin
      tick();
      check($sformatf("midrst no done %0d", c), {31'd0, done}, 32'd0);
    end
    run_op("50/6", 8'd50, 8'd6, 8'd8, 8'd2);

    // Start pulses while busy are ignored.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0; dividend = 8'd60; divisor = 8'd4;
    for (int c = 1; c <= N; c++) begin
      check($sformatf("ign busy c%0d", c), {31'd0, busy}, 32'd1);
      start = (c == 3 || c == 5) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    check_done("ignored", 8'd14, 8'd2);
    tick();
    check("ignored idle busy", {31'd0, busy}, 32'd0);
    check("ignored idle done", {31'd0, done}, 32'd0);

    // Back-to-back: start 60/4 on the done cycle of 100/7.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    tick();
    start = 1'b0;
    check_run("b2b first");
    start = 1'b1; dividend = 8'd60; divisor = 8'd4;
    check_done("b2b first", 8'd14, 8'd2);
    tick();
    start = 1'b0;
    check_run("b2b second");
    check_done("b2b second", 8'd15, 8'd0);
    tick();

    // A handful of pseudo-random pairs against the arithmetic reference.
    for (int k = 0; k < 12; k++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run_op($sformatf("rnd %0d/%0d", a, b), a, b, a / b, a % b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
